// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU micro-program issuer.
//   - ALU opcode encodings (3-bit alu_op values)
//   - 16-bit instruction word field positions
//   - issuer FSM state encoding
package alu_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;
  localparam int INSN_W   = 16;
  localparam int FIELD_W  = 3;
  localparam int LAT_W    = 4;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SHL  = 3'd5;
  localparam logic [2:0] ALU_SHR  = 3'd6;
  localparam logic [2:0] ALU_PASS = 3'd7;

  // Instruction word layout: [15:13] op, [12:10] rd, [9:7] rs1,
  // [6:4] rs2, [3] halt, [2:0] reserved
  localparam int OP_LSB   = 13;
  localparam int RD_LSB   = 10;
  localparam int RS1_LSB  = 7;
  localparam int RS2_LSB  = 4;
  localparam int HALT_BIT = 3;
  localparam int RSVD_MSB = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 8 x 32-bit register file for the ALU issuer.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset (clears all regs)
//   we, waddr, wdata  - single synchronous write port
//   raddr1/rdata1     - asynchronous read port (operand A)
//   raddr2/rdata2     - asynchronous read port (operand B)
//   dbg_addr/dbg_rdata- registered read port, data valid one cycle after address
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      dbg_rdata <= '0;
    end else begin
      if (we) begin
        regs[waddr] <= wdata;
      end
      // Readback shows the pre-write contents when address and write coincide
      dbg_rdata <= regs[dbg_addr];
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: sequential initiator for an external 32-bit combinational ALU.
// Steps through a small micro-program, issuing each instruction's operands
// from an 8-entry register file, waiting ALU_LAT cycles, then writing the
// result and flags back.
// Parameters:
//   PROG_DEPTH - micro-program entries (power of 2, 2..64)
//   ALU_LAT    - cycles the operands are held before the WB state (1..15)
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   start, abort            - begin at pc=0 (IDLE only) / cancel the run
//   prog_we/addr/wdata      - program memory write (IDLE only)
//   reg_we/addr/wdata       - register preload (IDLE only); reg_addr also
//                             selects the registered readback reg_rdata
//   alu_a, alu_b, alu_op    - registered ALU operands and control
//   alu_result, alu_zero/greater/less - ALU response
//   busy, done              - not-IDLE indicator / completion pulse
//   zero/greater/less_flag  - flags captured at the last write-back
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ALU_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [INSN_W-1:0]             prog_wdata,
  input  logic                          reg_we,
  input  logic [REG_AW-1:0]             reg_addr,
  input  logic [DATA_W-1:0]             reg_wdata,
  output logic [DATA_W-1:0]             reg_rdata,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  output logic [2:0]                    alu_op,
  input  logic [DATA_W-1:0]             alu_result,
  input  logic                          alu_zero,
  input  logic                          alu_greater,
  input  logic                          alu_less,
  output logic                          busy,
  output logic                          done,
  output logic                          zero_flag,
  output logic                          greater_flag,
  output logic                          less_flag
);

  localparam int                PC_W    = $clog2(PROG_DEPTH);
  localparam logic [PC_W-1:0]   PC_LAST = PC_W'(PROG_DEPTH - 1);
  localparam logic [LAT_W-1:0]  LAT_M1  = LAT_W'(ALU_LAT - 1);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [INSN_W-1:0] ir;
  logic [LAT_W-1:0]  wait_cnt;
  logic [INSN_W-1:0] prog [PROG_DEPTH];

  // Decoded instruction fields
  logic [FIELD_W-1:0] ir_op;
  logic [FIELD_W-1:0] ir_rd;
  logic [FIELD_W-1:0] ir_rs1;
  logic [FIELD_W-1:0] ir_rs2;
  logic               ir_halt;
  logic               rsvd_unused;

  assign ir_op       = ir[OP_LSB  +: FIELD_W];
  assign ir_rd       = ir[RD_LSB  +: FIELD_W];
  assign ir_rs1      = ir[RS1_LSB +: FIELD_W];
  assign ir_rs2      = ir[RS2_LSB +: FIELD_W];
  assign ir_halt     = ir[HALT_BIT];
  assign rsvd_unused = ^ir[RSVD_MSB:0];

  // Register file write port is shared between the IDLE preload and the
  // WB result write; the two are never active in the same state.
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = reg_addr;
    rf_wdata = reg_wdata;
    if (state == ST_IDLE) begin
      rf_we = reg_we;
    end else if (state == ST_WB && !abort) begin
      rf_we    = 1'b1;
      rf_waddr = ir_rd;
      rf_wdata = alu_result;
    end
  end

  alu_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (rf_we),
    .waddr     (rf_waddr),
    .wdata     (rf_wdata),
    .raddr1    (ir_rs1),
    .raddr2    (ir_rs2),
    .dbg_addr  (reg_addr),
    .rdata1    (rs1_data),
    .rdata2    (rs2_data),
    .dbg_rdata (reg_rdata)
  );

  // Program memory has no reset so a loaded program survives rst_n
  always_ff @(posedge clk) begin
    if (rst_n && state == ST_IDLE && prog_we) begin
      prog[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc           <= '0;
      ir           <= '0;
      wait_cnt     <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= ALU_ADD;
      busy         <= 1'b0;
      done         <= 1'b0;
      zero_flag    <= 1'b0;
      greater_flag <= 1'b0;
      less_flag    <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over every transition, including the WB write-back
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          // IDLE -> FETCH: launch at the first program entry
          ST_IDLE: begin
            if (start) begin
              pc    <= '0;
              state <= ST_FETCH;
              busy  <= 1'b1;
            end
          end
          // FETCH -> ISSUE: latch the instruction word
          ST_FETCH: begin
            ir    <= prog[pc];
            state <= ST_ISSUE;
          end
          // ISSUE -> WAIT: register operands; they hold until the next ISSUE
          ST_ISSUE: begin
            alu_a    <= rs1_data;
            alu_b    <= rs2_data;
            alu_op   <= ir_op;
            wait_cnt <= LAT_M1;
            state    <= ST_WAIT;
          end
          // WAIT -> WB: ALU_LAT cycles counted down from ALU_LAT-1
          ST_WAIT: begin
            if (wait_cnt == '0) begin
              state <= ST_WB;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          // WB -> FETCH/DONE: result written through rf_we; last entry always ends
          ST_WB: begin
            zero_flag    <= alu_zero;
            greater_flag <= alu_greater;
            less_flag    <= alu_less;
            if (ir_halt || pc == PC_LAST) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= ST_FETCH;
            end
          end
          // DONE -> IDLE: done pulse lasts exactly this state
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_op_issuer.sv
module tb_alu_op_issuer;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, prog_we, reg_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_greater, alu_less;
  logic        busy, done, zero_flag, greater_flag, less_flag;

  always #5 clk = ~clk;

  alu_op_issuer #(.PROG_DEPTH(DEPTH), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_greater(alu_greater), .alu_less(alu_less),
    .busy(busy), .done(done),
    .zero_flag(zero_flag), .greater_flag(greater_flag), .less_flag(less_flag)
  );

  // Behavioural ALU, shared by the external ALU and the reference interpreter
  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b;
      3'd6:    return a >> b;
      default: return a;
    endcase
  endfunction

  always_comb begin
    alu_result  = alu_f(alu_op, alu_a, alu_b);
    alu_zero    = (alu_result == 32'd0);
    alu_greater = (alu_a > alu_b);
    alu_less    = (alu_a < alu_b);
  end

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2, input int halt);
    logic [15:0] w;
    w = '0;
    w[15:13] = 3'(op);
    w[12:10] = 3'(rd);
    w[9:7]   = 3'(rs1);
    w[6:4]   = 3'(rs2);
    w[3]     = 1'(halt);
    return w;
  endfunction

  // Reference state
  logic [31:0] m_reg  [8];
  logic [15:0] m_prog [DEPTH];
  logic        m_z, m_g, m_l;

  typedef struct {
    int          cyc;
    logic        z, g, l;
    logic [2:0]  op;
    logic [31:0] a, b;
  } done_rec_t;
  typedef struct {
    logic [2:0]  addr;
    logic [31:0] val;
  } rd_rec_t;

  done_rec_t done_q[$];
  rd_rec_t   rd_q[$];
  done_rec_t dr;
  rd_rec_t   rr;

  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic rd_req = 1'b0;
  logic rd_vld;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    if (rd_vld === 1'b1) begin
      if (rd_q.size() == 0) chk("readback_underflow", rd_q.size(), 1);
      else begin
        rr = rd_q.pop_front();
        chk($sformatf("R%0d", rr.addr), reg_rdata, rr.val);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) chk("done_unexpected", {31'd0, done}, 0);
      else begin
        dr = done_q.pop_front();
        chk("done_cycle", cyc, dr.cyc);
        chk("zero_flag", {31'd0, zero_flag}, {31'd0, dr.z});
        chk("greater_flag", {31'd0, greater_flag}, {31'd0, dr.g});
        chk("less_flag", {31'd0, less_flag}, {31'd0, dr.l});
        chk("alu_op_hold", {29'd0, alu_op}, {29'd0, dr.op});
        chk("alu_a_hold", alu_a, dr.a);
        chk("alu_b_hold", alu_b, dr.b);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input int addr, input logic [31:0] val);
    reg_we = 1'b1; reg_addr = 3'(addr); reg_wdata = val;
    tick();
    reg_we = 1'b0;
    m_reg[addr] = val;
  endtask

  task automatic load_prog(input int idx, input logic [15:0] w);
    prog_we = 1'b1; prog_addr = 4'(idx); prog_wdata = w;
    tick();
    prog_we = 1'b0;
    m_prog[idx] = w;
  endtask

  // Straight-line interpreter of the micro-program
  task automatic model_run(output int n, output logic [2:0] lop, output logic [31:0] la, output logic [31:0] lb);
    logic [15:0] w;
    logic [31:0] r;
    n = 0; lop = '0; la = '0; lb = '0;
    for (int pc = 0; pc < DEPTH; pc++) begin
      w   = m_prog[pc];
      lop = w[15:13];
      la  = m_reg[w[9:7]];
      lb  = m_reg[w[6:4]];
      r   = alu_f(lop, la, lb);
      m_reg[w[12:10]] = r;
      m_z = (r == 32'd0);
      m_g = (la > lb);
      m_l = (la < lb);
      n++;
      if (w[3]) break;
    end
  endtask

  // Launch a run; when expect_done, the reference is executed and queued.
  // An optional preload is driven in the same cycle as start.
  task automatic launch(input bit expect_done, input bit pre, input int pa, input logic [31:0] pv);
    int n;
    done_rec_t d;
    if (expect_done) begin
      if (pre) m_reg[pa] = pv;
      model_run(n, d.op, d.a, d.b);
      d.cyc = cyc + 1 + n * (3 + LAT);
      d.z = m_z; d.g = m_g; d.l = m_l;
      done_q.push_back(d);
    end
    start = 1'b1;
    if (pre) begin reg_we = 1'b1; reg_addr = 3'(pa); reg_wdata = pv; end
    tick();
    start = 1'b0; reg_we = 1'b0;
  endtask

  // Wait for IDLE; optionally poke start/prog_we/reg_we while busy
  task automatic wait_idle(input bit poke);
    int k;
    k = 0;
    tick();
    while (busy === 1'b1 && k < 2000) begin
      if (poke && $urandom_range(0, 4) == 0) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = 4'($urandom); prog_wdata = 16'($urandom);
        reg_we = 1'b1; reg_addr = 3'($urandom); reg_wdata = $urandom;
      end
      tick();
      start = 1'b0; prog_we = 1'b0; reg_we = 1'b0;
      k++;
    end
    chk("busy_clears", {31'd0, k < 2000}, 1);
  endtask

  task automatic readback_all();
    for (int i = 0; i < 8; i++) begin
      rr.addr = 3'(i); rr.val = m_reg[i];
      rd_q.push_back(rr);
      reg_addr = 3'(i); rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 40));
      1:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_zero"}, {31'd0, zero_flag}, 0);
    chk({tag, "_greater"}, {31'd0, greater_flag}, 0);
    chk({tag, "_less"}, {31'd0, less_flag}, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_op"}, {29'd0, alu_op}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; prog_we = 1'b0; reg_we = 1'b0;
    prog_addr = '0; prog_wdata = '0; reg_addr = '0; reg_wdata = '0;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    for (int i = 0; i < DEPTH; i++) m_prog[i] = '0;
    m_z = 1'b0; m_g = 1'b0; m_l = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check_reset_outputs("reset");
    chk("reset_reg_rdata", reg_rdata, 0);
    readback_all();

    // ADD R3,R1,R2 halt
    preload(1, 32'd5); preload(2, 32'd1);
    load_prog(0, enc(0, 3, 1, 2, 1));
    launch(1'b1, 1'b0, 0, 0); wait_idle(1'b0); readback_all();

    // SUB R4,R1,R1 -> zero
    preload(1, 32'h0000_00FF);
    load_prog(0, enc(1, 4, 1, 1, 1));
    launch(1'b1, 1'b0, 0, 0); wait_idle(1'b0); readback_all();

    // 16 x PASS Rk,Rk without halt: last entry terminates
    for (int i = 0; i < DEPTH; i++) load_prog(i, enc(7, i % 8, i % 8, i % 8, 0));
    launch(1'b1, 1'b0, 0, 0); wait_idle(1'b1); readback_all();

    // XOR R5,R1,R2, alu_op held from WAIT through DONE
    preload(1, 32'hF0F0_F0F0); preload(2, 32'hFFFF_FFFF);
    load_prog(0, enc(4, 5, 1, 2, 1));
    launch(1'b1, 1'b0, 0, 0);
    tick(); tick();
    for (int i = 0; i < LAT + 2; i++) begin
      chk("xor_alu_op_stable", {29'd0, alu_op}, 4);
      tick();
    end
    wait_idle(1'b0); readback_all();

    // Abort during WAIT of SHL R6,R1,R2
    preload(6, 32'h1234_5678);
    load_prog(0, enc(5, 6, 1, 2, 1));
    launch(1'b0, 1'b0, 0, 0);
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_zero", {31'd0, zero_flag}, {31'd0, m_z});
    chk("abort_greater", {31'd0, greater_flag}, {31'd0, m_g});
    chk("abort_less", {31'd0, less_flag}, {31'd0, m_l});
    readback_all();

    // Randomized programs, with ignored pokes and start+preload overlap
    for (int run = 0; run < 30; run++) begin
      for (int i = 0; i < DEPTH; i++)
        load_prog(i, enc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), ($urandom_range(0, 5) == 0)) | 16'($urandom_range(0, 7)));
      for (int p = $urandom_range(0, 4); p > 0; p--) preload($urandom_range(0, 7), rval());
      launch(1'b1, ($urandom_range(0, 2) == 0), $urandom_range(0, 7), rval());
      wait_idle(1'b1);
      readback_all();
    end

    // Reset in the middle of a long run; program survives
    for (int i = 0; i < DEPTH; i++) load_prog(i, enc($urandom_range(0, 7), i % 8, $urandom_range(0, 7), $urandom_range(0, 7), 0));
    launch(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_z = 1'b0; m_g = 1'b0; m_l = 1'b0;
    check_reset_outputs("midrst");
    readback_all();
    preload(1, 32'd7); preload(2, 32'd3);
    launch(1'b1, 1'b0, 0, 0); wait_idle(1'b0); readback_all();

    chk("done_queue_drained", done_q.size(), 0);
    chk("readback_queue_drained", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Sequential initiator for the 32-bit combinational ALU. It holds a small micro-program and an 8-entry register file, and steps through the program one instruction at a time. For each instruction it drives operands and opcode to the ALU, waits a fixed latency, then writes the result and flags back. It sits between the test or control logic and the ALU, turning the ALU into a programmable datapath.

## Interface
- `PROG_DEPTH`, default 16: micro-program entries (power of 2, 2..64).
- `ALU_LAT`, default 1: cycles from operand issue to result sampling (1..15).
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `start` input, 1 bit: begin execution at pc=0; honoured only in IDLE.
- `abort` input, 1 bit: cancel execution; no write-back of the in-flight instruction.
- `prog_we` input, 1 bit: write `prog_wdata` to `prog[prog_addr]`; honoured only in IDLE.
- `prog_addr` input, log2(PROG_DEPTH) bits: program write address.
- `prog_wdata` input, 16 bits: instruction word.
- `reg_we` input, 1 bit: preload `R[reg_addr] <= reg_wdata`; honoured only in IDLE.
- `reg_addr` input, 3 bits: register preload/readback address.
- `reg_wdata` input, 32 bits: preload data.
- `reg_rdata` output, 32 bits: registered readback of `R[reg_addr]`, valid 1 cycle after address.
- `alu_a`, `alu_b` output, 32 bits each: ALU operands.
- `alu_op` output, 3 bits: ALU control.
- `alu_result` input, 32 bits: ALU result.
- `alu_zero`, `alu_greater`, `alu_less` input, 1 bit each: ALU flags.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse on normal completion.
- `zero_flag`, `greater_flag`, `less_flag` output, 1 bit each: flags captured at the last write-back.

## Operation
- Instruction fields: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3] halt, [2:0] reserved (ignored).
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 PASS (result = A).
- States:
  - IDLE: on `start`, go to FETCH with pc=0.
  - FETCH: `ir <= prog[pc]`.
  - ISSUE: register `alu_a=R[rs1]`, `alu_b=R[rs2]`, `alu_op=op`.
  - WAIT: hold for ALU_LAT cycles, counted down.
  - WB: `R[rd] <= alu_result`; capture the three flags. If halt=1 or pc==PROG_DEPTH-1, go to DONE; else pc+1 and go to FETCH.
  - DONE: `done`=1 for one cycle, then IDLE.
- pc never wraps; the last entry always terminates execution.
- `alu_a`, `alu_b`, `alu_op` remain stable from ISSUE through WB, and hold their values in IDLE.
- rd may equal rs1 or rs2; the write-back uses the sampled operands, so there is no hazard.
- `abort` in any non-IDLE state: next state is IDLE, no write-back, `done` stays low, flags are unchanged. Abort takes priority over the WB transition.
- `start`, `prog_we`, `reg_we` outside IDLE: ignored.
- `start` and `reg_we` together in IDLE: the preload completes first, and execution sees the new value.
- Arithmetic: modulo 2^32, no carry or overflow output. Shift amounts are taken from the full `alu_b`; the ALU defines the result.

## Timing
- Reset values: `busy`=0, `done`=0, all flags 0, `alu_a`=0, `alu_b`=0, `alu_op`=0, `reg_rdata`=0, pc=0, R0..R7=0, state IDLE.
- Program memory is not reset; its contents are retained across reset.
- Reset mid-run: state, registers and outputs return to their reset values on the next edge.
- Per instruction: 3+ALU_LAT cycles (FETCH, ISSUE, WAIT×ALU_LAT, WB).
- `done` asserts the cycle after the final WB. `busy` falls together with `done` deasserting, when IDLE is re-entered.
- For N instructions from the `start` edge: `done` high at cycle N·(3+ALU_LAT)+1.
- `alu_result` is sampled at the end of the WB cycle, ALU_LAT+1 cycles after the operands change.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (`ALU_ADD`..`ALU_PASS`);
  - instruction field positions;
  - state encoding (IDLE, FETCH, ISSUE, WAIT, WB, DONE).
- One natural sub-module, `alu_regfile`: 8×32, one sync write port, two async read ports plus one registered debug read port.
- Program memory and FSM stay in `alu_op_issuer`.

## Test plan
1. Preload R1=5, R2=1; prog[0]=ADD R3,R1,R2, halt; start, ALU_LAT=1 -> `done` at cycle 5; R3=0x6; zero_flag=0.
2. Preload R1=0xFF; prog[0]=SUB R4,R1,R1, halt -> R4=0; zero_flag=1.
3. All 16 entries PASS Rk,Rk, halt=0 -> exactly 16 write-backs; `done` at cycle 65; pc stops at 15, no wrap.
4. ALU_LAT=3; prog[0]=XOR R5,R1,R2 with R1=0xF0F0F0F0, R2=0xFFFFFFFF -> `alu_op`=100 stable for 5 cycles; R5=0x0F0F0F0F.
5. `abort` during WAIT of SHL R6,R1,R2 -> R6 unchanged, `busy`=0 next cycle, no `done`.
6. `start`/`prog_we` pulsed while busy are ignored; `rst_n`=0 mid-run -> all outputs and R0..R7 read 0, and the program still executes after restart.
